// File: rtl/time_pkg.sv
// Shared types and helpers for the HH:MM:SS set controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package time_pkg;

  // Controller modes; the encoding doubles as the FIELD code shown to the display
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HR   = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  localparam logic [7:0] HR_MAX_DEF = 8'h23;
  localparam logic [7:0] MS_MAX_DEF = 8'h59;

  // Wrapping BCD increment; any non-BCD input is treated as corrupt and restarts at 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = val[7:4];
    lo = val[3:0];
    if ((val == max_val) || (hi > 4'd9) || (lo > 4'd9)) begin
      return 8'h00;
    end else if (lo == 4'd9) begin
      return {hi + 4'd1, 4'd0};
    end else begin
      return {hi, lo + 4'd1};
    end
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-FF synchronizer, optional debounce (TIME_SET_DEBOUNCE_EN), rising-edge pulse.
// Latency: PRESS rises 2 edges after the first edge sampling BTN high (+DEB_CYC with debounce).
// Backpressure: none; one registered single-cycle pulse per press, regardless of hold time.
module btn_cond
  #(
    parameter int unsigned DEB_CYC = 20
  )
  (
    input  logic CLK1K,
    input  logic RSTN,
    input  logic BTN,
    output logic PRESS
  );

  if ((DEB_CYC < 1) || (DEB_CYC > 255)) begin : g_deb_range
    $error("btn_cond: DEB_CYC must be in 1..255");
  end

  logic sync1;
  logic sync2;
  logic lvl;
  logic lvl_d;

  // Bring the asynchronous button into the CLK1K domain
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
    end
  end

`ifdef TIME_SET_DEBOUNCE_EN
  logic [7:0] deb_cnt;
  logic       deb_lvl;

  // Accept a new level only after DEB_CYC consecutive samples disagree with the current one
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      deb_cnt <= 8'd0;
      deb_lvl <= 1'b0;
    end else if (sync2 == deb_lvl) begin
      deb_cnt <= 8'd0;
    end else if (deb_cnt == 8'(DEB_CYC - 1)) begin
      deb_cnt <= 8'd0;
      deb_lvl <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign lvl = deb_lvl;
`else
  assign lvl = sync2;
`endif

  // Registered rising-edge detect: one pulse per press
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      lvl_d <= 1'b0;
      PRESS <= 1'b0;
    end else begin
      lvl_d <= lvl;
      PRESS <= lvl & ~lvl_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/set controller for the HH:MM:SS BCD chain: 1 Hz SEC_EN in RUN, load strobes in SET modes.
// Latency: LOAD_x/SET_VAL rise 3 edges after BTN_INC is first sampled high (+DEB_CYC with TIME_SET_DEBOUNCE_EN).
// Backpressure: none; counters accept a load on any cycle, strobes are single-cycle.
module time_set_ctrl
  import time_pkg::*;
  #(
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 250,
    parameter logic [7:0]  HR_MAX    = HR_MAX_DEF,
    parameter logic [7:0]  MS_MAX    = MS_MAX_DEF,
    parameter int unsigned DEB_CYC   = 20
  )
  (
    input  logic       CLK1K,
    input  logic       RSTN,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    input  logic [7:0] HR_BCD,
    input  logic [7:0] MIN_BCD,
    input  logic [7:0] SEC_BCD,
    output logic       SEC_EN,
    output logic       LOAD_HR,
    output logic       LOAD_MIN,
    output logic       LOAD_SEC,
    output logic [7:0] SET_VAL,
    output logic [1:0] FIELD,
    output logic       BLINK
  );

  if ((TICK_DIV < 2) || (TICK_DIV > 1023)) begin : g_tick_range
    $error("time_set_ctrl: TICK_DIV must be in 2..1023");
  end
  if ((BLINK_DIV < 2) || (BLINK_DIV > 255)) begin : g_blink_range
    $error("time_set_ctrl: BLINK_DIV must be in 2..255");
  end

  state_t     state;
  state_t     state_nxt;
  logic [9:0] presc;
  logic [7:0] blink_cnt;
  logic       mode_p;
  logic       inc_p;

  btn_cond #(.DEB_CYC(DEB_CYC)) u_btn_mode (
    .CLK1K (CLK1K),
    .RSTN  (RSTN),
    .BTN   (BTN_MODE),
    .PRESS (mode_p)
  );

  btn_cond #(.DEB_CYC(DEB_CYC)) u_btn_inc (
    .CLK1K (CLK1K),
    .RSTN  (RSTN),
    .BTN   (BTN_INC),
    .PRESS (inc_p)
  );

  // Fixed mode ring advanced by each MODE press
  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN:     state_nxt = ST_SET_HR;
      ST_SET_HR:  state_nxt = ST_SET_MIN;
      ST_SET_MIN: state_nxt = ST_SET_SEC;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Mode register and blink phase; blink restarts from 0 on every mode change
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_RUN;
      blink_cnt <= 8'd0;
      BLINK     <= 1'b0;
    end else if (mode_p) begin
      state     <= state_nxt;
      blink_cnt <= 8'd0;
      BLINK     <= 1'b0;
    end else if (state == ST_RUN) begin
      blink_cnt <= 8'd0;
      BLINK     <= 1'b0;
    end else if (blink_cnt == 8'(BLINK_DIV - 1)) begin
      blink_cnt <= 8'd0;
      BLINK     <= ~BLINK;
    end else begin
      blink_cnt <= blink_cnt + 8'd1;
    end
  end

  // Seconds prescaler: free-runs only while staying in RUN, so leaving SET restarts a full period
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      presc  <= 10'd0;
      SEC_EN <= 1'b0;
    end else if ((state == ST_RUN) && !mode_p) begin
      if (presc == 10'(TICK_DIV - 1)) begin
        presc  <= 10'd0;
        SEC_EN <= 1'b1;
      end else begin
        presc  <= presc + 10'd1;
        SEC_EN <= 1'b0;
      end
    end else begin
      presc  <= 10'd0;
      SEC_EN <= 1'b0;
    end
  end

  // INC in a SET mode loads the incremented field; a coincident MODE press drops the INC
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      LOAD_HR  <= 1'b0;
      LOAD_MIN <= 1'b0;
      LOAD_SEC <= 1'b0;
      SET_VAL  <= 8'h00;
    end else begin
      LOAD_HR  <= 1'b0;
      LOAD_MIN <= 1'b0;
      LOAD_SEC <= 1'b0;
      if (inc_p && !mode_p) begin
        case (state)
          ST_SET_HR: begin
            LOAD_HR <= 1'b1;
            SET_VAL <= bcd_inc(HR_BCD, HR_MAX);
          end
          ST_SET_MIN: begin
            LOAD_MIN <= 1'b1;
            SET_VAL  <= bcd_inc(MIN_BCD, MS_MAX);
          end
          ST_SET_SEC: begin
            LOAD_SEC <= 1'b1;
            SET_VAL  <= bcd_inc(SEC_BCD, MS_MAX);
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Field indication follows the mode directly
  always_comb begin
    FIELD = FLD_NONE;
    case (state)
      ST_SET_HR:  FIELD = FLD_HR;
      ST_SET_MIN: FIELD = FLD_MIN;
      ST_SET_SEC: FIELD = FLD_SEC;
      default:    FIELD = FLD_NONE;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: cycle model of the mode/set behaviour plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_time_set_ctrl;

  localparam int TICK = 10;
  localparam int BLK  = 6;
  localparam int DEB  = 20;
`ifdef TIME_SET_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = 3 + DEB;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = 3;
`endif
  localparam int HOLD = 30;
  localparam int GAP  = 40;
  localparam int HN   = 16384;

  logic       CLK1K    = 1'b0;
  logic       RSTN     = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_INC  = 1'b0;
  logic [7:0] HR_BCD   = 8'h00;
  logic [7:0] MIN_BCD  = 8'h00;
  logic [7:0] SEC_BCD  = 8'h00;
  logic       SEC_EN, LOAD_HR, LOAD_MIN, LOAD_SEC, BLINK;
  logic [7:0] SET_VAL;
  logic [1:0] FIELD;

  time_set_ctrl #(
    .TICK_DIV  (TICK),
    .BLINK_DIV (BLK),
    .HR_MAX    (8'h23),
    .MS_MAX    (8'h59),
    .DEB_CYC   (DEB)
  ) dut (
    .CLK1K    (CLK1K),
    .RSTN     (RSTN),
    .BTN_MODE (BTN_MODE),
    .BTN_INC  (BTN_INC),
    .HR_BCD   (HR_BCD),
    .MIN_BCD  (MIN_BCD),
    .SEC_BCD  (SEC_BCD),
    .SEC_EN   (SEC_EN),
    .LOAD_HR  (LOAD_HR),
    .LOAD_MIN (LOAD_MIN),
    .LOAD_SEC (LOAD_SEC),
    .SET_VAL  (SET_VAL),
    .FIELD    (FIELD),
    .BLINK    (BLINK)
  );

  always #5 CLK1K = ~CLK1K;

  int checks = 0;
  int errors = 0;

  // What each active edge saw
  int         cyc = 0;
  bit         edge_ok = 1'b0;
  bit         smp_m, smp_i;
  logic [7:0] smp_hr, smp_min, smp_sec;

  always @(posedge CLK1K) begin
    edge_ok = RSTN;
    if (RSTN) cyc = cyc + 1;
    else      cyc = 0;
    smp_m   = BTN_MODE;
    smp_i   = BTN_INC;
    smp_hr  = HR_BCD;
    smp_min = MIN_BCD;
    smp_sec = SEC_BCD;
  end

  // Raw sample history and conditioned button level per edge index
  bit sm [HN];
  bit si [HN];
  bit gm [HN];
  bit gi [HN];

  function automatic bit s_at(input bit is_inc, input int k);
    if (k < 1 || k >= HN) return 1'b0;
    return is_inc ? si[k] : sm[k];
  endfunction

  function automatic bit g_at(input bit is_inc, input int k);
    if (k < 1 || k >= HN) return 1'b0;
    return is_inc ? gi[k] : gm[k];
  endfunction

  // Conditioned level: raw sample, or with debounce a level that flips only after DEB agreeing samples
  function automatic bit filt(input bit is_inc, input int k);
    bit v;
    bit all_eq;
    if (!DEB_ON) return s_at(is_inc, k);
    v      = ~g_at(is_inc, k - 1);
    all_eq = 1'b1;
    for (int j = k - DEB; j < k; j++) begin
      if (s_at(is_inc, j) != v) all_eq = 1'b0;
    end
    return all_eq ? v : g_at(is_inc, k - 1);
  endfunction

  // Decimal +1 with wrap at max; anything non-BCD restarts at 00
  function automatic logic [7:0] m_inc(input logic [7:0] v, input logic [7:0] mx);
    int hi, lo, n;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9 || v == mx) return 8'h00;
    n = hi * 10 + lo + 1;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Model state: mode index, edges spent in current mode, last load
  int         m_state = 0;
  int         m_run = 0;
  int         m_set = 0;
  bit         m_sec = 1'b0;
  int         m_load = 0;
  logic [7:0] m_val = 8'h00;
  bit         act_m, act_i, exp_blink;
  logic [14:0] got_v, exp_v;

  // Observations used by the directed literal checks
  int         sec_q[$];
  int         n_loads = 0;
  int         ld_fld = 0;
  logic [7:0] ld_val = 8'h00;
  int         ld_cyc = 0;

  always @(negedge CLK1K) begin
    if (!RSTN) begin
      m_state = 0; m_run = 0; m_set = 0; m_sec = 1'b0; m_load = 0; m_val = 8'h00;
      sec_q.delete();
    end else if (edge_ok && cyc < HN) begin
      sm[cyc] = smp_m;
      si[cyc] = smp_i;
      gm[cyc] = filt(1'b0, cyc);
      gi[cyc] = filt(1'b1, cyc);
      act_m = g_at(1'b0, cyc - 3) && !g_at(1'b0, cyc - 4);
      act_i = g_at(1'b1, cyc - 3) && !g_at(1'b1, cyc - 4);
      m_sec  = 1'b0;
      m_load = 0;
      if (act_m) begin
        m_state = (m_state + 1) % 4;
        m_run   = 0;
        m_set   = 0;
      end else if (m_state == 0) begin
        m_run = m_run + 1;
        m_sec = (m_run % TICK) == 0;
      end else begin
        m_set = m_set + 1;
        if (act_i) begin
          m_load = m_state;
          case (m_state)
            1:       m_val = m_inc(smp_hr, 8'h23);
            2:       m_val = m_inc(smp_min, 8'h59);
            default: m_val = m_inc(smp_sec, 8'h59);
          endcase
        end
      end
    end
    exp_blink = (m_state != 0) && (((m_set / BLK) % 2) == 1);
    got_v = {SEC_EN, LOAD_HR, LOAD_MIN, LOAD_SEC, SET_VAL, FIELD, BLINK};
    exp_v = {m_sec, m_load == 1, m_load == 2, m_load == 3, m_val, 2'(m_state), exp_blink};
    checks = checks + 1;
    if (got_v !== exp_v) begin
      errors = errors + 1;
      $display("FAIL cycle_model cyc=%0d: got sec/lh/lm/ls/val/fld/blk=%h, required %h", cyc, got_v, exp_v);
    end
    checks = checks + 1;
    if ($countones({SEC_EN, LOAD_HR, LOAD_MIN, LOAD_SEC}) > 1) begin
      errors = errors + 1;
      $display("FAIL strobe_exclusive cyc=%0d: got %b, required at most one high", cyc, {SEC_EN, LOAD_HR, LOAD_MIN, LOAD_SEC});
    end
    if (RSTN) begin
      if (SEC_EN) sec_q.push_back(cyc);
      if (LOAD_HR || LOAD_MIN || LOAD_SEC) begin
        n_loads = n_loads + 1;
        ld_fld  = LOAD_HR ? 1 : (LOAD_MIN ? 2 : 3);
        ld_val  = SET_VAL;
        ld_cyc  = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK1K);
    #1;
  endtask

  int press_cyc = 0;

  task automatic press(input bit m, input bit i, input int len);
    BTN_MODE  = m;
    BTN_INC   = i;
    press_cyc = cyc + 1;
    tick(len);
    BTN_MODE  = 1'b0;
    BTN_INC   = 1'b0;
    tick(GAP);
  endtask

  int loads_before;

  initial begin
    tick(3);
    chk("reset_outputs", {SEC_EN, LOAD_HR, LOAD_MIN, LOAD_SEC, SET_VAL, FIELD, BLINK}, 0);
    RSTN = 1'b1;

    tick(35);
    chk("sec_en_count", sec_q.size(), 3);
    chk("sec_en_1st", sec_q[0], 10);
    chk("sec_en_2nd", sec_q[1], 20);
    chk("sec_en_3rd", sec_q[2], 30);

    press(1'b1, 1'b0, HOLD);
    chk("field_hr", FIELD, 1);

    HR_BCD = 8'h19;
    press(1'b0, 1'b1, HOLD);
    chk("hr_19_fld", ld_fld, 1);
    chk("hr_19_val", ld_val, 8'h20);
    chk("inc_latency", ld_cyc - press_cyc, LAT);

    HR_BCD = 8'h23;
    press(1'b0, 1'b1, HOLD);
    chk("hr_23_val", ld_val, 8'h00);
    chk("hr_loads", n_loads, 2);

    press(1'b1, 1'b0, HOLD);
    chk("field_min", FIELD, 2);
    MIN_BCD = 8'h59;
    press(1'b0, 1'b1, HOLD);
    chk("min_59_val", ld_val, 8'h00);
    MIN_BCD = 8'h3A;
    press(1'b0, 1'b1, HOLD);
    chk("min_3a_val", ld_val, 8'h00);
    MIN_BCD = 8'h09;
    press(1'b0, 1'b1, HOLD);
    chk("min_09_fld", ld_fld, 2);
    chk("min_09_val", ld_val, 8'h10);

    MIN_BCD = 8'h12;
    loads_before = n_loads;
    press(1'b1, 1'b1, HOLD);
    chk("mode_inc_field", FIELD, 3);
    chk("mode_inc_noload", n_loads, loads_before);

    SEC_BCD = 8'h45;
    press(1'b0, 1'b1, 50);
    chk("hold50_loads", n_loads, loads_before + 1);
    chk("hold50_fld", ld_fld, 3);
    chk("hold50_val", ld_val, 8'h46);

    // Reset while an INC press is still in the pipeline
    SEC_BCD      = 8'h10;
    loads_before = n_loads;
    BTN_INC      = 1'b1;
    tick(2);
    RSTN = 1'b0;
    #2;
    chk("midreset_outputs", {SEC_EN, LOAD_HR, LOAD_MIN, LOAD_SEC, SET_VAL, FIELD, BLINK}, 0);
    BTN_INC = 1'b0;
    tick(3);
    RSTN = 1'b1;
    tick(40);
    chk("midreset_noload", n_loads, loads_before);
    chk("midreset_field", FIELD, 0);
    chk("midreset_sec", sec_q[0], 10);

    // Walk back round to RUN; first SEC_EN one full period after the mode change
    press(1'b1, 1'b0, HOLD);
    press(1'b1, 1'b0, HOLD);
    press(1'b1, 1'b0, HOLD);
    chk("field_sec_again", FIELD, 3);
    sec_q.delete();
    press(1'b1, 1'b0, HOLD);
    chk("back_to_run", FIELD, 0);
    chk("resume_sec", sec_q[0], press_cyc + LAT + TICK);

`ifdef TIME_SET_DEBOUNCE_EN
    press(1'b1, 1'b0, HOLD);
    HR_BCD       = 8'h05;
    loads_before = n_loads;
    BTN_INC      = 1'b1;
    tick(5);
    BTN_INC      = 1'b0;
    tick(GAP);
    chk("glitch_noload", n_loads, loads_before);
    press(1'b0, 1'b1, HOLD);
    chk("deb_press_load", n_loads, loads_before + 1);
    chk("deb_press_val", ld_val, 8'h06);
    chk("deb_latency", ld_cyc - press_cyc, 3 + DEB);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Mode/set controller for the HH:MM:SS chain of 2-digit BCD counters, all clocked from CLK1K.
- In RUN, generates the 1 Hz count-enable pulse into the seconds counter.
- In SET modes, it:
  - stops counting;
  - turns conditioned MODE/INC button presses into one-cycle load strobes plus an 8-bit BCD load value for the selected field;
  - provides a field-select and blink indication for the display.

Parameters:
- TICK_DIV, 1000: CLK1K cycles per SEC_EN pulse (10-bit prescaler; legal range 2..1023).
- BLINK_DIV, 250: CLK1K cycles per BLINK toggle (8-bit counter; legal range 2..255).
- HR_MAX, 8'h23: hours wrap value (BCD).
- MS_MAX, 8'h59: minutes/seconds wrap value (BCD).
- DEB_CYC, 20: stable cycles required per button when DEBOUNCE_EN is defined.

Ports:
- CLK1K, input, 1: 1 kHz system clock.
- RSTN, input, 1: asynchronous active-low reset.
- BTN_MODE, input, 1: raw mode button, active-high, asynchronous.
- BTN_INC, input, 1: raw increment button, active-high, asynchronous.
- HR_BCD, input, 8: current hours counter value.
- MIN_BCD, input, 8: current minutes counter value.
- SEC_BCD, input, 8: current seconds counter value.
- SEC_EN, output, 1: count enable to the seconds counter; one-cycle pulse.
- LOAD_HR, output, 1: one-cycle load strobe for the hours counter.
- LOAD_MIN, output, 1: one-cycle load strobe for the minutes counter.
- LOAD_SEC, output, 1: one-cycle load strobe for the seconds counter.
- SET_VAL, output, 8: BCD value to load; valid while any LOAD_* is high.
- FIELD, output, 2: field being edited. 0 = none (RUN), 1 = HR, 2 = MIN, 3 = SEC.
- BLINK, output, 1: blink phase for the edited field; held 0 in RUN.

Behaviour:
- Reset (RSTN low, asynchronous):
  - state = RUN; prescaler = 0; blink counter = 0; sync and debounce flops = 0.
  - All outputs 0, including SET_VAL = 8'h00.
  - Reset asserted mid-edit abandons the edit; no LOAD strobe is issued.
- Button path:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector. One press gives one internal pulse, regardless of hold time.
  - Without DEBOUNCE_EN, a LOAD strobe rises 3 CLK1K edges after the first edge that samples BTN_INC high.
- FSM states: RUN, SET_HR, SET_MIN, SET_SEC. Each MODE pulse advances RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN. No other transitions exist.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. SEC_EN is registered and high for exactly the one cycle after the prescaler reaches TICK_DIV-1, at which point it wraps to 0.
  - INC pulses are ignored. FIELD = 0, BLINK = 0.
- SET_x states:
  - Prescaler is held at 0 and SEC_EN = 0.
  - On leaving SET_SEC for RUN, the first SEC_EN occurs TICK_DIV cycles later.
  - An INC pulse computes next = bcd_inc(current field input, max), where max is HR_MAX for hours and MS_MAX otherwise.
  - SET_VAL <= next and LOAD_x <= 1 are registered together; LOAD_x is high for exactly one cycle. SET_VAL holds its last value afterwards.
- bcd_inc rules:
  - If the value equals max, or either nibble exceeds 9 (non-BCD), the result is 8'h00.
  - Else if the low nibble is 9, the result is {hi+1, 0}.
  - Else the result is {hi, lo+1}.
- Simultaneous MODE and INC pulses in the same cycle: MODE wins; INC is dropped and no LOAD is issued.
- At most one LOAD_* is high in any cycle. LOAD_* and SEC_EN are never high together.
- BLINK: in SET states, toggles every BLINK_DIV cycles. The blink counter and BLINK reset to 0 on every state change.

Optional Feature:
- Macro: TIME_SET_DEBOUNCE_EN.
- Defined: each synchronized button feeds a counter that must see DEB_CYC consecutive equal samples before the debounced level updates. Edge detection runs on the debounced level, so glitches shorter than DEB_CYC produce no pulse and latency grows by DEB_CYC cycles.
- Undefined: edge detection runs directly on the synchronizer output; no debounce counter is instantiated.

Decomposition:
- Shared package time_pkg holds:
  - state enum (RUN, SET_HR, SET_MIN, SET_SEC);
  - FIELD encodings;
  - HR_MAX/MS_MAX defaults;
  - the bcd_inc function.
- One sub-module, btn_cond, is instantiated twice. It contains the synchronizer, the optional debounce and the edge detector. Its output is a one-cycle press pulse.

Test Plan:
- TICK_DIV=10, RUN, no buttons, reset release -> SEC_EN pulses at cycles 10, 20, 30. Exactly one cycle wide, never two consecutive.
- MODE pressed once -> FIELD=1, SEC_EN stays 0. INC with HR_BCD=8'h19 -> LOAD_HR one cycle, SET_VAL=8'h20. INC with HR_BCD=8'h23 -> SET_VAL=8'h00.
- MODE x2 -> FIELD=2. INC with MIN_BCD=8'h59 -> LOAD_MIN, SET_VAL=8'h00. INC with MIN_BCD=8'h3A (non-BCD) -> SET_VAL=8'h00.
- MODE and INC rising in the same cycle while in SET_MIN -> state goes to SET_SEC (FIELD=3), no LOAD_* asserted. INC held high 50 cycles -> exactly one LOAD_SEC.
- RSTN asserted while in SET_SEC with an INC in flight -> all outputs 0 immediately, no LOAD after release, state RUN, SEC_EN resumes after TICK_DIV.
- With TIME_SET_DEBOUNCE_EN and DEB_CYC=20: 5-cycle INC glitch -> no LOAD. 30-cycle press -> one LOAD, 20 cycles later than the non-debounced build.
